// File: rtl/ldvio_pkg.sv
// Shared types and default sizing for the load-violation write controller.
// An ldvio_entry_t packs {addr, data}; queue slots use the same layout.
package ldvio_pkg;
  localparam int LDVIO_INDEX  = 4;
  localparam int LDVIO_WIDTH  = 8;
  localparam int LDVIO_NREQ   = 2;
  localparam int LDVIO_QDEPTH = 4;

  typedef struct packed {
    logic [LDVIO_INDEX-1:0] addr;
    logic [LDVIO_WIDTH-1:0] data;
  } ldvio_entry_t;
endpackage

// File: rtl/ldvio_queue.sv
// Multi-push / single-pop circular queue of {addr,data} words.
// Ports: flush/pop, wr_cnt+wr_data (compacted pushes), or_mask (in-place
// OR per slot), head_data, head_ptr, count, slots, slot_vld.
module ldvio_queue
  import ldvio_pkg::*;
#(
  parameter int DW    = LDVIO_INDEX + LDVIO_WIDTH,
  parameter int DEPTH = LDVIO_QDEPTH,
  parameter int NW    = LDVIO_NREQ
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      pop,
  input  logic [$clog2(NW+1)-1:0]   wr_cnt,
  input  logic [NW-1:0][DW-1:0]     wr_data,
  input  logic [DEPTH-1:0][DW-1:0]  or_mask,
  output logic [DW-1:0]             head_data,
  output logic [$clog2(DEPTH)-1:0]  head_ptr,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0][DW-1:0]  slots,
  output logic [DEPTH-1:0]          slot_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] off;

  assign head_data = mem[head_q];
  assign head_ptr  = head_q;
  assign count     = count_q;
  assign slots     = mem;

  // A slot is live when its distance from head is below the count.
  always_comb begin
    off      = '0;
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PW'(i) - head_q;
      slot_vld[i] = CW'(off) < count_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] <= mem[i] | or_mask[i];
    for (int k = 0; k < NW; k++)
      if ($clog2(NW+1)'(k) < wr_cnt)
        mem[tail_q + PW'(k)] <= wr_data[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(pop);
      tail_q  <= tail_q + PW'(wr_cnt);
      count_q <= count_q + CW'(wr_cnt) - CW'(pop);
    end
  end
endmodule

// File: rtl/ldvio_write_ctrl.sv
// Queues LSU load-violation reports and drains them into a 1-port RAM.
// Macro LDVIO_COALESCE_EN: merge same-address reports by OR-ing data.
module ldvio_write_ctrl
  import ldvio_pkg::*;
#(
  parameter int INDEX  = LDVIO_INDEX,
  parameter int WIDTH  = LDVIO_WIDTH,
  parameter int NREQ   = LDVIO_NREQ,
  parameter int QDEPTH = LDVIO_QDEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [NREQ-1:0][INDEX-1:0]  req_addr_i,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_data_i,
  output logic                        req_ready_o,
  output logic [INDEX-1:0]            addr0wr_o,
  output logic [WIDTH-1:0]            data0wr_o,
  output logic                        we0_o,
  output logic [$clog2(QDEPTH):0]     pending_o,
  output logic                        err_o
);
  localparam int EW  = INDEX + WIDTH;
  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;
  localparam int NCW = $clog2(NREQ+1);

  logic [CW-1:0]                count;
  logic [PW-1:0]                head_ptr;
  logic [EW-1:0]                head_data;
  logic [QDEPTH-1:0][EW-1:0]    slots;
  logic [QDEPTH-1:0]            slot_vld;
  logic [NCW-1:0]               wr_cnt;
  logic [NREQ-1:0][EW-1:0]      wr_data;
  logic [QDEPTH-1:0][EW-1:0]    or_mask;
  logic [CW-1:0]                free;
  logic [NREQ-1:0]              acc;
  logic                         pop;
  int                           n;

  assign free        = CW'(QDEPTH) - count;
  assign req_ready_o = free >= CW'(NREQ);
  assign acc = req_valid_i & {NREQ{req_ready_o & ~flush_i}};
  assign pop = ~flush_i & (count != '0);
  assign pending_o = count;

`ifdef LDVIO_COALESCE_EN
  logic            hit;
  logic [NREQ-1:0] alloc_own;
  int              alloc_idx [NREQ];

  // Merge into a live slot (not the one leaving), else into an earlier
  // port's fresh allocation, else allocate at the next tail position.
  always_comb begin
    wr_data   = '0;
    or_mask   = '0;
    alloc_own = '0;
    hit       = 1'b0;
    n         = 0;
    for (int p = 0; p < NREQ; p++) alloc_idx[p] = 0;
    for (int p = 0; p < NREQ; p++) begin
      hit = 1'b0;
      if (acc[p]) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (!hit && slot_vld[i] &&
              !(pop && PW'(i) == head_ptr) &&
              slots[i][EW-1:WIDTH] == req_addr_i[p]) begin
            hit = 1'b1;
            or_mask[i][WIDTH-1:0] =
              or_mask[i][WIDTH-1:0] | req_data_i[p];
          end
        end
        for (int q = 0; q < NREQ; q++) begin
          if (!hit && q < p && alloc_own[q] &&
              req_addr_i[q] == req_addr_i[p]) begin
            hit = 1'b1;
            for (int k = 0; k < NREQ; k++)
              if (k == alloc_idx[q])
                wr_data[k][WIDTH-1:0] =
                  wr_data[k][WIDTH-1:0] | req_data_i[p];
          end
        end
        if (!hit) begin
          for (int k = 0; k < NREQ; k++)
            if (k == n)
              wr_data[k] = {req_addr_i[p], req_data_i[p]};
          alloc_own[p] = 1'b1;
          alloc_idx[p] = n;
          n = n + 1;
        end
      end
    end
    wr_cnt = NCW'(n);
  end

  logic unused_ok;
  assign unused_ok = 1'b0;
`else
  always_comb begin
    wr_data = '0;
    or_mask = '0;
    n       = 0;
    for (int p = 0; p < NREQ; p++) begin
      if (acc[p]) begin
        for (int k = 0; k < NREQ; k++)
          if (k == n)
            wr_data[k] = {req_addr_i[p], req_data_i[p]};
        n = n + 1;
      end
    end
    wr_cnt = NCW'(n);
  end

  logic unused_ok;
  assign unused_ok = ^{slots, slot_vld, head_ptr};
`endif

  ldvio_queue #(
    .DW    (EW),
    .DEPTH (QDEPTH),
    .NW    (NREQ)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_i),
    .pop       (pop),
    .wr_cnt    (wr_cnt),
    .wr_data   (wr_data),
    .or_mask   (or_mask),
    .head_data (head_data),
    .head_ptr  (head_ptr),
    .count     (count),
    .slots     (slots),
    .slot_vld  (slot_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we0_o     <= 1'b0;
      addr0wr_o <= '0;
      data0wr_o <= '0;
      err_o     <= 1'b0;
    end else begin
      we0_o <= pop;
      if (pop)
        {addr0wr_o, data0wr_o} <= head_data;
      if (!flush_i && |(req_valid_i & ~{NREQ{req_ready_o}}))
        err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ldvio_write_ctrl.sv
// Bench for ldvio_write_ctrl: queue-level reference model plus literals.
// Build with +define+LDVIO_COALESCE_EN to exercise the merging variant.
module tb_ldvio_write_ctrl;
  import ldvio_pkg::*;

  localparam int NREQ   = 2;
  localparam int QDEPTH = 4;
  localparam int INDEX  = 4;
  localparam int WIDTH  = 8;

  logic                       clk;
  logic                       reset;
  logic                       flush;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][INDEX-1:0] req_addr;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic                       ready;
  logic [INDEX-1:0]           addr0;
  logic [WIDTH-1:0]           data0;
  logic                       we0;
  logic [$clog2(QDEPTH):0]    pending;
  logic                       err;

  int n_pass = 0;
  int n_tot  = 0;

  ldvio_write_ctrl #(
    .INDEX(INDEX), .WIDTH(WIDTH), .NREQ(NREQ), .QDEPTH(QDEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .req_valid_i(req_valid),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .req_ready_o(ready),
    .addr0wr_o  (addr0),
    .data0wr_o  (data0),
    .we0_o      (we0),
    .pending_o  (pending),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: a list of pending reports, drained one per edge.
  ldvio_entry_t mq[$];
  bit           m_we;
  bit [3:0]     m_addr;
  bit [7:0]     m_data;
  bit           m_err;
  bit           m_rdy;
  bit           m_found;
  ldvio_entry_t m_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
    end else begin
      m_rdy = (QDEPTH - mq.size()) >= NREQ;
      if (flush) begin
        mq.delete();
        m_we = 0;
      end else begin
        if (!m_rdy && req_valid != 0) m_err = 1;
        if (mq.size() > 0) begin
          m_we = 1;
          m_addr = mq[0].addr;
          m_data = mq[0].data;
          void'(mq.pop_front());
        end else m_we = 0;
        if (m_rdy)
          for (int p = 0; p < NREQ; p++)
            if (req_valid[p]) begin
              m_found = 0;
`ifdef LDVIO_COALESCE_EN
              foreach (mq[j])
                if (!m_found && mq[j].addr == req_addr[p]) begin
                  mq[j].data = mq[j].data | req_data[p];
                  m_found = 1;
                end
`endif
              if (!m_found) begin
                m_e.addr = req_addr[p];
                m_e.data = req_data[p];
                mq.push_back(m_e);
              end
            end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready",   ready,   32'((QDEPTH - mq.size()) >= NREQ));
    chk("pending", pending, 32'(mq.size()));
    chk("we0",     we0,     m_we);
    chk("addr0",   addr0,   m_addr);
    chk("data0",   data0,   m_data);
    chk("err",     err,     m_err);
  end

  task automatic drive(bit [1:0] v, bit [3:0] a0, bit [7:0] d0,
                       bit [3:0] a1, bit [7:0] d1, bit fl);
    req_valid   = v;
    req_addr[0] = a0; req_data[0] = d0;
    req_addr[1] = a1; req_data[1] = d1;
    flush       = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1; flush = 0; req_valid = '0;
    req_addr = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_we", we0, 0);
    chk("rst_pend", pending, 0);
    chk("rst_err", err, 0);
    reset = 0;
    idle(1);

    drive(2'b01, 3, 8'h01, 0, 0, 0);
    chk("lat_we_e0", we0, 0);
    chk("lat_pend_e0", pending, 1);
    idle(1);
    chk("lat_we_e1", we0, 1);
    chk("lat_addr_e1", addr0, 3);
    chk("lat_data_e1", data0, 8'h01);
    idle(1);
    chk("lat_we_e2", we0, 0);
    chk("hold_addr", addr0, 3);

    drive(2'b11, 1, 8'h11, 2, 8'h22, 0);
    drive(2'b11, 3, 8'h33, 4, 8'h44, 0);
    chk("dual_ready", ready, 0);
    chk("dual_pend", pending, 3);
    chk("dual_w1", addr0, 1);
    idle(1); chk("dual_w2", addr0, 2);
    idle(1); chk("dual_w3", addr0, 3);
    idle(1); chk("dual_w4", {addr0, data0}, {4'd4, 8'h44});
    idle(1); chk("dual_done", we0, 0);
    chk("dual_err", err, 0);

    drive(2'b11, 6, 8'h06, 7, 8'h07, 0);
    drive(2'b11, 8, 8'h08, 9, 8'h09, 0);
    chk("fl_pre", pending, 3);
    drive(2'b11, 10, 8'h0a, 11, 8'h0b, 1);
    chk("fl_pend", pending, 0);
    chk("fl_we", we0, 0);
    chk("fl_err", err, 0);
    chk("fl_hold", addr0, 6);
    idle(3);

    drive(2'b11, 5, 8'h01, 5, 8'h04, 0);
`ifdef LDVIO_COALESCE_EN
    chk("co_pend", pending, 1);
    idle(1); chk("co_w", {we0, addr0, data0}, {1'b1, 4'd5, 8'h05});
    idle(1); chk("co_end", we0, 0);
`else
    chk("co_pend", pending, 2);
    idle(1); chk("co_w1", {we0, addr0, data0}, {1'b1, 4'd5, 8'h01});
    idle(1); chk("co_w2", {we0, addr0, data0}, {1'b1, 4'd5, 8'h04});
    idle(1); chk("co_end", we0, 0);
`endif

    drive(2'b11, 1, 8'h01, 2, 8'h02, 0);
    drive(2'b11, 3, 8'h03, 4, 8'h04, 0);
    drive(2'b11, 5, 8'h05, 6, 8'h06, 0);
    chk("ovf_err", err, 1);
    chk("ovf_pend", pending, 2);
    idle(5);
    chk("ovf_sticky", err, 1);

    drive(2'b11, 1, 8'h01, 2, 8'h02, 0);
    drive(2'b11, 3, 8'h03, 4, 8'h04, 0);
    idle(1);
    chk("mid_we", we0, 1);
    reset = 1;
    #1;
    chk("mid_we_rst", we0, 0);
    chk("mid_pend_rst", pending, 0);
    chk("mid_err_rst", err, 0);
    @(posedge clk); #1;
    reset = 0;
    idle(4);
    chk("mid_no_wr", we0, 0);
    chk("mid_pend", pending, 0);

    for (int c = 0; c < 60; c++)
      drive(2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 8'(1 << $urandom_range(0, 7)),
            4'($urandom_range(0, 3)), 8'(1 << $urandom_range(0, 7)),
            $urandom_range(0, 15) == 0);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
